// File: rtl/switch_cmd_scheduler_pkg.sv
// Shared command codes, FSM states and small helpers for the switch command scheduler.
package switch_cmd_scheduler_pkg;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_START = 2'd1;
   localparam logic [1:0] CMD_CLEAR = 2'd2;
   localparam logic [1:0] CMD_RESET = 2'd3;

   localparam int CNT_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_GAP
   } sched_state_e;

   // Pending flags are {RESET, CLEAR, START}; RESET outranks CLEAR outranks START.
   function automatic logic [1:0] pickCmd(input logic [2:0] pend);
      if (pend[2])      return CMD_RESET;
      else if (pend[1]) return CMD_CLEAR;
      else if (pend[0]) return CMD_START;
      else              return CMD_NONE;
   endfunction

   // An accepted RESET wipes every pending request, the others only their own flag.
   function automatic logic [2:0] clearMask(input logic [1:0] code);
      case (code)
         CMD_RESET: return 3'b111;
         CMD_CLEAR: return 3'b010;
         CMD_START: return 3'b001;
         default:   return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/switch_cmd_scheduler_if.sv
// Command handshake between the scheduler (master) and the LCD command engine (slave).
interface switch_cmd_scheduler_if;

   logic       CMD_VALID;
   logic [1:0] CMD_CODE;
   logic       CMD_READY;
   logic       CMD_DONE;

   modport master (
      output CMD_VALID,
      output CMD_CODE,
      input  CMD_READY,
      input  CMD_DONE
   );

   modport slave (
      input  CMD_VALID,
      input  CMD_CODE,
      output CMD_READY,
      output CMD_DONE
   );

endinterface

// File: rtl/switch_cmd_scheduler_edge.sv
// Three-bit rising-edge detector; history resets to 1 so levels held through reset stay silent.
module sched_edge_detect (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] i_level,
   output logic [2:0] o_rise
);

   logic [2:0] r_prev;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_prev <= 3'b111;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/switch_cmd_scheduler.sv
// Turns debounced START/CLEAR/RESET switch edges into prioritised, rate-limited LCD commands.
import switch_cmd_scheduler_pkg::*;

module switch_cmd_scheduler #(
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          D0,
   input  logic                          D1,
   input  logic                          D2,
   switch_cmd_scheduler_if.master        cmd,
   output logic                          BUSY,
   output logic [2:0]                    PEND,
   output logic                          ERR
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

   sched_state_e     r_state;
   logic             r_cmdValid;
   logic [1:0]       r_cmdCode;
   logic [2:0]       r_pend;
   logic             r_err;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;

   logic [2:0]       w_rise;
   logic [2:0]       w_clr;

   sched_edge_detect u_edge (
      .CLK     (CLK),
      .RST     (RST),
      .i_level ({D2, D1, D0}),
      .o_rise  (w_rise)
   );

   always_comb begin
      w_clr = 3'b000;
      if (r_state == ST_ISSUE && cmd.CMD_READY) begin
         w_clr = clearMask(r_cmdCode);
      end
   end

   // One counter serves both WAIT_DONE timeout and GAP length; it is reloaded on every entry.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_cmdValid <= 1'b0;
         r_cmdCode  <= CMD_NONE;
         r_pend     <= 3'b000;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_rise;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_pend != 3'b000) begin
                  r_state    <= ST_ISSUE;
                  r_cmdValid <= 1'b1;
                  r_cmdCode  <= pickCmd(r_pend);
                  r_busy     <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (cmd.CMD_READY) begin
                  r_state    <= ST_WAIT_DONE;
                  r_cmdValid <= 1'b0;
                  r_cmdCode  <= CMD_NONE;
                  r_cnt      <= '0;
               end
            end
            ST_WAIT_DONE: begin
               if (cmd.CMD_DONE) begin
                  r_state <= ST_GAP;
                  r_cnt   <= '0;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_state <= ST_GAP;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_cmdValid <= 1'b0;
               r_cmdCode  <= CMD_NONE;
               r_busy     <= 1'b0;
               r_cnt      <= '0;
            end
         endcase
      end
   end

   assign cmd.CMD_VALID = r_cmdValid;
   assign cmd.CMD_CODE  = r_cmdCode;
   assign BUSY          = r_busy;
   assign PEND          = r_pend;
   assign ERR           = r_err;

endmodule

// File: tb/tb_switch_cmd_scheduler.sv
// Directed bench for switch_cmd_scheduler: reset, priority, back-pressure, timeout, gap and set-wins cases.
module tb_switch_cmd_scheduler;

   logic       CLK = 1'b0;
   logic       RST;
   logic       D0, D1, D2;
   logic       BUSY;
   logic [2:0] PEND;
   logic       ERR;

   int assertCount = 0;
   int failCount   = 0;

   switch_cmd_scheduler_if cmdIf ();

   switch_cmd_scheduler #(
      .GAP_CYCLES     (16),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .D0   (D0),
      .D1   (D1),
      .D2   (D2),
      .cmd  (cmdIf),
      .BUSY (BUSY),
      .PEND (PEND),
      .ERR  (ERR)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive switches {D2,D1,D0}, READY and DONE, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic [2:0] d, input logic ready, input logic done);
      {D2, D1, D0}    = d;
      cmdIf.CMD_READY = ready;
      cmdIf.CMD_DONE  = done;
      @(posedge CLK);
      #1;
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int n = 0;
      while (BUSY && n < budget) begin
         applyStimulus({D2, D1, D0}, 1'b0, 1'b0);
         n++;
      end
      checkOutput(tag, BUSY, 0);
   endtask

   initial begin
      int validSeen;
      int badCycles;
      int errCycle;
      int errPulses;
      int idleCycle;
      int n;

      RST = 1'b0;
      {D2, D1, D0} = 3'b000;
      cmdIf.CMD_READY = 1'b0;
      cmdIf.CMD_DONE  = 1'b0;

      // Reset with START held high
      repeat (3) applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("rst_valid", cmdIf.CMD_VALID, 0);
      checkOutput("rst_code", cmdIf.CMD_CODE, 0);
      checkOutput("rst_pend", PEND, 0);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_err", ERR, 0);

      RST = 1'b1;
      validSeen = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(3'b001, 1'b0, 1'b0);
         if (cmdIf.CMD_VALID) validSeen++;
      end
      checkOutput("held_no_valid", validSeen, 0);
      checkOutput("held_no_pend", PEND, 0);

      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("start_pend", PEND, 3'b001);
      checkOutput("start_valid_early", cmdIf.CMD_VALID, 0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("start_valid", cmdIf.CMD_VALID, 1);
      checkOutput("start_code", cmdIf.CMD_CODE, 1);
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("start_acc_valid", cmdIf.CMD_VALID, 0);
      checkOutput("start_acc_code", cmdIf.CMD_CODE, 0);
      checkOutput("start_acc_pend", PEND, 0);
      checkOutput("start_acc_busy", BUSY, 1);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b1);
      waitIdle(30, "start_idle");

      // All three edges together: a single RESET command covers them
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b111, 1'b1, 1'b0);
      checkOutput("all_pend", PEND, 3'b111);
      applyStimulus(3'b111, 1'b1, 1'b0);
      checkOutput("all_valid", cmdIf.CMD_VALID, 1);
      checkOutput("all_code", cmdIf.CMD_CODE, 3);
      applyStimulus(3'b111, 1'b1, 1'b0);
      checkOutput("all_acc_pend", PEND, 0);
      checkOutput("all_acc_valid", cmdIf.CMD_VALID, 0);
      applyStimulus(3'b111, 1'b0, 1'b0);
      applyStimulus(3'b111, 1'b0, 1'b0);
      applyStimulus(3'b111, 1'b0, 1'b1);
      validSeen = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(3'b111, 1'b1, 1'b0);
         if (cmdIf.CMD_VALID) validSeen++;
      end
      checkOutput("all_no_more_cmds", validSeen, 0);
      checkOutput("all_pend_after", PEND, 0);
      checkOutput("all_busy_after", BUSY, 0);

      // CLEAR held off by READY low
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      checkOutput("clr_pend", PEND, 3'b010);
      applyStimulus(3'b010, 1'b0, 1'b0);
      checkOutput("clr_valid", cmdIf.CMD_VALID, 1);
      checkOutput("clr_code", cmdIf.CMD_CODE, 2);
      badCycles = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(3'b010, 1'b0, 1'b0);
         if (cmdIf.CMD_VALID !== 1'b1 || cmdIf.CMD_CODE !== 2'd2) badCycles++;
      end
      checkOutput("clr_stable", badCycles, 0);
      applyStimulus(3'b010, 1'b1, 1'b0);
      checkOutput("clr_acc_valid", cmdIf.CMD_VALID, 0);
      checkOutput("clr_acc_pend", PEND, 0);
      applyStimulus(3'b010, 1'b0, 1'b1);
      waitIdle(30, "clr_idle");

      // Timeout: DONE never arrives
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b1, 1'b0);
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("to_valid", cmdIf.CMD_VALID, 1);
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("to_acc_valid", cmdIf.CMD_VALID, 0);
      errCycle = 0;
      errPulses = 0;
      idleCycle = 0;
      for (int i = 1; i <= 200; i++) begin
         applyStimulus(3'b001, 1'b0, 1'b0);
         if (ERR) begin
            errPulses++;
            if (errCycle == 0) errCycle = i;
         end
         if (!BUSY && idleCycle == 0) begin
            idleCycle = i;
            break;
         end
      end
      checkOutput("to_err_cycle", errCycle, 50);
      checkOutput("to_err_pulses", errPulses, 1);
      checkOutput("to_idle_cycle", idleCycle, 66);

      // START edge arriving during GAP
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b1, 1'b0);
      applyStimulus(3'b010, 1'b1, 1'b0);
      applyStimulus(3'b010, 1'b1, 1'b0);
      checkOutput("gap_acc_valid", cmdIf.CMD_VALID, 0);
      applyStimulus(3'b010, 1'b0, 1'b1);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b011, 1'b0, 1'b0);
      checkOutput("gap_pend", PEND, 3'b001);
      checkOutput("gap_busy", BUSY, 1);
      n = 0;
      while (BUSY && n < 50) begin
         applyStimulus(3'b011, 1'b0, 1'b0);
         n++;
      end
      checkOutput("gap_remaining", n, 13);
      checkOutput("gap_end_valid", cmdIf.CMD_VALID, 0);
      applyStimulus(3'b011, 1'b0, 1'b0);
      checkOutput("gap_next_valid", cmdIf.CMD_VALID, 1);
      checkOutput("gap_next_code", cmdIf.CMD_CODE, 1);

      // Reset while a command is being offered
      RST = 1'b0;
      applyStimulus(3'b011, 1'b1, 1'b0);
      checkOutput("midrst_valid", cmdIf.CMD_VALID, 0);
      checkOutput("midrst_code", cmdIf.CMD_CODE, 0);
      checkOutput("midrst_pend", PEND, 0);
      checkOutput("midrst_busy", BUSY, 0);
      RST = 1'b1;
      repeat (5) applyStimulus(3'b011, 1'b0, 1'b0);
      checkOutput("midrst_quiet_pend", PEND, 0);
      checkOutput("midrst_quiet_valid", cmdIf.CMD_VALID, 0);

      // Edge in the same cycle as the handshake keeps its flag set
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("sw_valid", cmdIf.CMD_VALID, 1);
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("sw_pend", PEND, 3'b001);
      checkOutput("sw_acc_valid", cmdIf.CMD_VALID, 0);
      applyStimulus(3'b001, 1'b0, 1'b1);
      waitIdle(30, "sw_idle");
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("sw_reissue_valid", cmdIf.CMD_VALID, 1);
      checkOutput("sw_reissue_code", cmdIf.CMD_CODE, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
